// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer: FSM encoding,
// vector/counter widths and the per-vector compare helper.
package tt_seq_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // True when the sampled output disagrees with the golden bit for this vector.
    function automatic logic vec_mismatch(
        input logic                   f,
        input logic [NUM_VECTORS-1:0] tbl,
        input logic [IDX_W-1:0]       idx
    );
        return (f != tbl[idx]);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Dwell counter: loaded with SETTLE_CYCLES-1, counts down while enabled and
// flags expiry when it reaches zero.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES - 1);

    logic [7:0] count_r;

    // Down-counter register; saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (en && (count_r != 8'd0)) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry decode.
    always_comb begin
        expire = (count_r == 8'd0);
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a 4-input circuit through all 16 vectors, captures its output and
// compares it against a golden truth table latched at start.
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_VECTORS-1:0] expected,
    input  logic                   F,
    output logic                   A,
    output logic                   B,
    output logic                   C,
    output logic                   D,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] captured,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic [IDX_W-1:0]       first_fail,
    output logic                   pass
);

    state_t                 state_r, state_s;
    logic [IDX_W-1:0]       index_r, index_s;
    logic [IDX_W-1:0]       vec_r, vec_s;
    logic [NUM_VECTORS-1:0] golden_r;
    logic [NUM_VECTORS-1:0] captured_s;
    logic [CNT_W-1:0]       count_s;
    logic [IDX_W-1:0]       first_s;
    logic                   pass_s;
    logic                   load_s, accept_s, sample_s, miss_s, expire_s;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .en     (state_r == APPLY),
        .expire (expire_s)
    );

    // Next-state and vector index; abort outranks everything, including start in IDLE.
    always_comb begin
        state_s  = state_r;
        index_s  = index_r;
        load_s   = 1'b0;
        accept_s = 1'b0;
        sample_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    accept_s = 1'b1;
                    load_s   = 1'b1;
                    index_s  = {IDX_W{1'b0}};
                    state_s  = APPLY;
                end else begin
                    state_s = IDLE;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (expire_s) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = APPLY;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_s = IDLE;
                end else begin
                    sample_s = 1'b1;
                    if (index_r == LAST_IDX) begin
                        state_s = FINISH;
                    end else begin
                        state_s = APPLY;
                        index_s = index_r + 4'd1;
                        load_s  = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (state_s == IDLE) begin
            index_s = {IDX_W{1'b0}};
        end else begin
            index_s = index_s;
        end
    end

    // Result datapath; results survive abort and only clear on an accepted start.
    always_comb begin
        captured_s = captured;
        count_s    = mismatch_count;
        first_s    = first_fail;
        pass_s     = pass;
        miss_s     = vec_mismatch(F, golden_r, index_r);
        if (accept_s) begin
            captured_s = {NUM_VECTORS{1'b0}};
            count_s    = {CNT_W{1'b0}};
            first_s    = {IDX_W{1'b0}};
            pass_s     = 1'b0;
        end else if (sample_s) begin
            captured_s[index_r] = F;
            if (miss_s) begin
                if (count_s == 5'd0) begin
                    first_s = index_r;
                end else begin
                    first_s = first_s;
                end
                count_s = count_s + 5'd1;
            end else begin
                count_s = count_s;
            end
            if (state_s == FINISH) begin
                pass_s = (count_s == 5'd0);
            end else begin
                pass_s = pass_s;
            end
        end else begin
            pass_s = pass_s;
        end
        if ((state_s == APPLY) || (state_s == SAMPLE)) begin
            vec_s = index_s;
        end else begin
            vec_s = {IDX_W{1'b0}};
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            index_r        <= {IDX_W{1'b0}};
            vec_r          <= {IDX_W{1'b0}};
            golden_r       <= {NUM_VECTORS{1'b0}};
            captured       <= {NUM_VECTORS{1'b0}};
            mismatch_count <= {CNT_W{1'b0}};
            first_fail     <= {IDX_W{1'b0}};
            pass           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_r        <= state_s;
            index_r        <= index_s;
            vec_r          <= vec_s;
            golden_r       <= accept_s ? expected : golden_r;
            captured       <= captured_s;
            mismatch_count <= count_s;
            first_fail     <= first_s;
            pass           <= pass_s;
            busy           <= (state_s != IDLE);
            done           <= (state_s == FINISH);
        end
    end

    assign {A, B, C, D} = vec_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: predicted sweep results are queued at start and compared
// when done pulses; a second instance exercises SETTLE_CYCLES=3 back-to-back.
module tb_truth_table_sequencer;

    typedef struct packed {
        logic [15:0] cap;
        logic [4:0]  mm;
        logic [3:0]  ff;
        logic        pass;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, f, f_zero;
    logic [15:0] expected;
    logic        a, b, c, d, busy, done, pass;
    logic [15:0] captured;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail;

    logic        start3, f3, a3, b3, c3, d3, busy3, done3, pass3;
    logic [15:0] captured3;
    logic [4:0]  mismatch_count3;
    logic [3:0]  first_fail3;
    logic [3:0]  vec3_log [0:299];

    result_t sb_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    always #5 clk = ~clk;

    assign f  = f_zero ? 1'b0 : (a ^ b ^ c ^ d);
    assign f3 = a3 ^ b3 ^ c3 ^ d3;

    truth_table_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .F(f), .A(a), .B(b), .C(c), .D(d), .busy(busy), .done(done),
        .captured(captured), .mismatch_count(mismatch_count),
        .first_fail(first_fail), .pass(pass)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .expected(16'h6996),
        .F(f3), .A(a3), .B(b3), .C(c3), .D(d3), .busy(busy3), .done(done3),
        .captured(captured3), .mismatch_count(mismatch_count3),
        .first_fail(first_fail3), .pass(pass3)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic result_t model(input logic [15:0] tbl, input logic zero);
        result_t    r;
        logic [3:0] v;
        logic       fv;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            v  = i[3:0];
            fv = zero ? 1'b0 : ^v;
            r.cap[i] = fv;
            if (fv != tbl[i]) begin
                if (r.mm == 5'd0) r.ff = v;
                r.mm = r.mm + 5'd1;
            end
        end
        r.pass = (r.mm == 5'd0);
        return r;
    endfunction

    // Cycle 0 is the cycle in which start is sampled; done is expected in cycle 33.
    task automatic run_sweep(input logic [15:0] tbl, input logic zero, input logic repulse, input string tag);
        result_t e;
        int      n;
        logic    seen;
        f_zero   = zero;
        expected = tbl;
        sb_q.push_back(model(tbl, zero));
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        expected = ~tbl;
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (repulse && n == 5) ? 1'b1 : 1'b0;
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        check_value({tag, "_latency"}, n, 33);
        e = sb_q.pop_front();
        if (seen) begin
            check_value({tag, "_captured"}, captured, e.cap);
            check_value({tag, "_mm"}, mismatch_count, e.mm);
            if (e.mm != 5'd0) check_value({tag, "_first_fail"}, first_fail, e.ff);
            check_value({tag, "_pass"}, pass, e.pass);
            check_value({tag, "_busy_at_done"}, busy, 1);
            @(negedge clk);
            check_value({tag, "_done_width"}, done, 0);
            check_value({tag, "_busy_after"}, busy, 0);
            check_value({tag, "_hold_captured"}, captured, e.cap);
        end
    endtask

    initial begin
        int n;
        int dones;
        int last_idle;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; expected = 16'h0000; f_zero = 1'b0; start3 = 1'b0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_vec", {a, b, c, d}, 0);
        check_value("rst_results", {captured, mismatch_count, first_fail, pass}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(16'h6996, 1'b0, 1'b0, "xor_ok");
        run_sweep(16'h6997, 1'b0, 1'b0, "xor_bit0");
        run_sweep(16'hFFFF, 1'b1, 1'b0, "f_zero");
        run_sweep(16'h6996 ^ 16'h0100, 1'b0, 1'b0, "xor_bit8");
        run_sweep(16'h6996 ^ 16'hA000, 1'b0, 1'b1, "repulse");

        // Abort raised in cycle 10: vectors 0..3 captured, vector 4 not.
        f_zero = 1'b0; expected = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_value("abort_busy", busy, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check_value("abort_no_done", dones, 0);
        check_value("abort_captured", captured, 16'h0006);
        check_value("abort_mm", mismatch_count, 2);
        check_value("abort_pass", pass, 0);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_value("start_abort_idle", busy, 0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-sweep, away from any clock edge.
        expected = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_rst_busy", busy, 0);
        check_value("mid_rst_vec", {a, b, c, d}, 0);
        check_value("mid_rst_results", {captured, mismatch_count, first_fail, pass, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(16'h6996, 1'b0, 1'b0, "post_rst");

        // SETTLE_CYCLES=3, start held high across two sweeps.
        start3 = 1'b1;
        @(negedge clk);
        n = 1; dones = 0; last_idle = 0;
        while (dones < 2 && n < 300) begin
            vec3_log[n] = {a3, b3, c3, d3};
            if (!busy3) last_idle = n;
            if (done3) begin
                dones++;
                check_value("s3_latency", n - last_idle, 65);
                check_value("s3_mm", mismatch_count3, 0);
                check_value("s3_pass", pass3, 1);
            end
            @(negedge clk);
            n++;
        end
        start3 = 1'b0;
        check_value("s3_two_sweeps", dones, 2);
        for (int k = 0; k < 16; k++) begin
            check_value("s3_vec_hold", {vec3_log[4*k+1], vec3_log[4*k+2], vec3_log[4*k+3]},
                        {k[3:0], k[3:0], k[3:0]});
        end
        check_value("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
